// File: rtl/fle_pkg.sv
// Shared constants for the fracturable logic element: configuration field
// offsets and chain length, all derived from the LUT input count K.
package fle_pkg;

  function automatic int cfg_len(input int k);
    return (1 << k) + 4;
  endfunction

  function automatic int LUT_LSB(input int k);
    return 0 * k;
  endfunction

  function automatic int FRAC_BIT(input int k);
    return (1 << k);
  endfunction

  function automatic int FFEN0_BIT(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int FFEN1_BIT(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int REGIN_BIT(input int k);
    return (1 << k) + 3;
  endfunction

endpackage

// File: rtl/fle_ccff_chain.sv
// Configuration shift chain: shifts one bit per cycle while config_en is high,
// holds otherwise. The tail is the registered MSB.
module fle_ccff_chain #(
  parameter int CFG_LEN = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               config_en,
  input  logic               ccff_head,
  output logic [CFG_LEN-1:0] cfg,
  output logic               ccff_tail
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what makes this a true shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {cfg[CFG_LEN-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CFG_LEN-1];

endmodule

// File: rtl/fle_frac_param.sv
// Fracturable logic element: K-LUT (or two (K-1)-LUTs), two bypassable
// flip-flops with register-chain and scan inputs, and a private config chain.
module fle_frac_param
  import fle_pkg::*;
#(
  parameter int K       = 4,
  parameter int FRAC_EN = 1,
  parameter int CFG_LEN = cfg_len(K)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         config_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic         Test_en,
  input  logic [K-1:0] fle_in,
  input  logic         fle_regin,
  input  logic         fle_scin,
  output logic [1:0]   fle_out,
  output logic         fle_regout,
  output logic         fle_scout
);

  localparam int LUT_SIZE  = 1 << K;
  localparam int LUT_IDX   = LUT_LSB(K);
  localparam int FRAC_IDX  = FRAC_BIT(K);
  localparam int FFEN0_IDX = FFEN0_BIT(K);
  localparam int FFEN1_IDX = FFEN1_BIT(K);
  localparam int REGIN_IDX = REGIN_BIT(K);

  logic [CFG_LEN-1:0]  cfg;
  logic [LUT_SIZE-1:0] truth;
  logic                fractured;
  logic [K-1:0]        idx_lo;
  logic [K-1:0]        idx_hi;
  logic                lut0;
  logic                lut1;
  logic                ff0;
  logic                ff1;

  fle_ccff_chain #(.CFG_LEN(CFG_LEN)) u_ccff (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .ccff_head (ccff_head),
    .cfg       (cfg),
    .ccff_tail (ccff_tail)
  );

  assign truth     = cfg[LUT_IDX +: LUT_SIZE];
  assign fractured = (FRAC_EN != 0) && cfg[FRAC_IDX];
  // Fractured halves: lower half of the table drives lut0, upper half lut1.
  assign idx_lo    = {1'b0, fle_in[K-2:0]};
  assign idx_hi    = {1'b1, fle_in[K-2:0]};

  // NOTE: outputs get a default before any branch so no latch is inferred.
  always_comb begin
    lut0 = truth[fle_in];
    lut1 = lut0;
    if (fractured) begin
      lut0 = truth[idx_lo];
      lut1 = truth[idx_hi];
    end
  end

  // Configuration outranks scan, which outranks the functional path.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff0 <= 1'b0;
      ff1 <= 1'b0;
    end else if (config_en) begin
      ff0 <= ff0;
      ff1 <= ff1;
    end else if (Test_en) begin
      ff0 <= fle_scin;
      ff1 <= ff0;
    end else begin
      ff0 <= cfg[REGIN_IDX] ? fle_regin : lut0;
      ff1 <= lut1;
    end
  end

  always_comb begin
    fle_out = '0;
    if (!config_en) begin
      fle_out[0] = cfg[FFEN0_IDX] ? ff0 : lut0;
      fle_out[1] = cfg[FFEN1_IDX] ? ff1 : lut1;
    end
  end

  assign fle_regout = ff0;
  assign fle_scout  = ff1;

endmodule

// File: tb/tb_fle_frac_param.sv
// Scoreboard bench for fle_frac_param (K=4): stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_fle_frac_param;

  localparam int K = 4;

  typedef enum int {S_OUT, S_REGOUT, S_SCOUT, S_TAIL, S_OUT_NF, S_CFG_ANY} sel_e;

  typedef struct {
    sel_e       sel;
    logic [1:0] exp;
    string      name;
  } sb_item_t;

  logic         clk;
  logic         reset;
  logic         config_en;
  logic         ccff_head;
  logic         Test_en;
  logic [K-1:0] fle_in;
  logic         fle_regin;
  logic         fle_scin;

  logic         ccff_tail, ccff_tail_nf;
  logic [1:0]   fle_out, fle_out_nf;
  logic         fle_regout, fle_regout_nf;
  logic         fle_scout, fle_scout_nf;

  sb_item_t     sb_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  fle_frac_param #(.K(K), .FRAC_EN(1)) u_dut (
    .clk(clk), .reset(reset), .config_en(config_en), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .Test_en(Test_en), .fle_in(fle_in),
    .fle_regin(fle_regin), .fle_scin(fle_scin), .fle_out(fle_out),
    .fle_regout(fle_regout), .fle_scout(fle_scout)
  );

  fle_frac_param #(.K(K), .FRAC_EN(0)) u_dut_nf (
    .clk(clk), .reset(reset), .config_en(config_en), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail_nf), .Test_en(Test_en), .fle_in(fle_in),
    .fle_regin(fle_regin), .fle_scin(fle_scin), .fle_out(fle_out_nf),
    .fle_regout(fle_regout_nf), .fle_scout(fle_scout_nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare everything queued since the last rising edge.
  initial begin
    sb_item_t   it;
    logic [1:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        case (it.sel)
          S_OUT:     act = fle_out;
          S_REGOUT:  act = {1'b0, fle_regout};
          S_SCOUT:   act = {1'b0, fle_scout};
          S_TAIL:    act = {1'b0, ccff_tail};
          S_OUT_NF:  act = fle_out_nf;
          default:   act = {1'b0, |u_dut.cfg};
        endcase
        check(it.name, act, it.exp);
      end
    end
  end

  task automatic expect_val(input sel_e sel, input logic [1:0] v, input string name);
    sb_item_t it;
    it.sel  = sel;
    it.exp  = v;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift a full configuration word, MSB first so bit i ends up in cfg[i].
  task automatic load_cfg(input logic [19:0] v);
    config_en = 1'b1;
    for (int i = 19; i >= 0; i--) begin
      ccff_head = v[i];
      expect_val(S_OUT, 2'b00, "cfg_isolation");
      step();
    end
    config_en = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic and4_checks(input string tag);
    fle_in = 4'hF;
    expect_val(S_OUT, 2'b11, {tag, "_in_f"});
    step();
    fle_in = 4'hE;
    expect_val(S_OUT, 2'b00, {tag, "_in_e"});
    step();
  endtask

  localparam logic [39:0] CHAIN_PAT = 40'hA5A5_3C3C_F0;

  initial begin
    reset = 1'b1; config_en = 1'b0; ccff_head = 1'b0; Test_en = 1'b0;
    fle_in = '0; fle_regin = 1'b0; fle_scin = 1'b0;
    step();
    step();
    expect_val(S_OUT,     2'b00, "rst_out");
    expect_val(S_REGOUT,  2'b00, "rst_regout");
    expect_val(S_SCOUT,   2'b00, "rst_scout");
    expect_val(S_TAIL,    2'b00, "rst_tail");
    expect_val(S_CFG_ANY, 2'b00, "rst_cfg");
    step();
    reset = 1'b0;

    // AND4, combinational
    load_cfg(20'h0_8000);
    and4_checks("and4");

    // Registered: input changes after edge n, output follows after edge n+1
    load_cfg(20'h6_8000);
    fle_in = 4'hE;
    step();
    expect_val(S_OUT, 2'b00, "reg_before");
    fle_in = 4'hF;
    expect_val(S_OUT, 2'b00, "reg_not_yet");
    step();
    expect_val(S_OUT, 2'b11, "reg_after");
    step();

    // Fracture (and the FRAC_EN=0 twin sharing the same configuration)
    load_cfg(20'h1_CCAA);
    fle_in = 4'b0001;
    expect_val(S_OUT,    2'b01, "frac_0001");
    expect_val(S_OUT_NF, 2'b11, "nofrac_0001");
    step();
    fle_in = 4'b1010;
    expect_val(S_OUT,    2'b10, "frac_1010");
    expect_val(S_OUT_NF, 2'b11, "nofrac_1010");
    step();

    // Scan chain: regout = scin delayed 1, scout delayed 2
    Test_en = 1'b1;
    fle_scin = 1'b1; step();
    expect_val(S_REGOUT, 2'b01, "scan_r1");
    fle_scin = 1'b0; step();
    expect_val(S_REGOUT, 2'b00, "scan_r2");
    expect_val(S_SCOUT,  2'b01, "scan_s2");
    fle_scin = 1'b1; step();
    expect_val(S_REGOUT, 2'b01, "scan_r3");
    expect_val(S_SCOUT,  2'b00, "scan_s3");
    fle_scin = 1'b0; step();
    expect_val(S_REGOUT, 2'b00, "scan_r4");
    expect_val(S_SCOUT,  2'b01, "scan_s4");

    // Chain pass-through with Test_en also high: config wins, flops hold
    fle_scin = 1'b1;
    fle_in = 4'hF;
    config_en = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      ccff_head = CHAIN_PAT[40-s];
      expect_val(S_OUT,    2'b00, "chain_isolation");
      expect_val(S_REGOUT, 2'b00, "chain_hold_regout");
      expect_val(S_SCOUT,  2'b01, "chain_hold_scout");
      step();
      if (s >= 20 && s <= 39)
        expect_val(S_TAIL, {1'b0, CHAIN_PAT[59-s]}, "chain_tail");
    end
    config_en = 1'b0;
    ccff_head = 1'b0;
    Test_en = 1'b0;
    fle_scin = 1'b0;

    // Register-chain input
    load_cfg(20'h8_0000);
    fle_regin = 1'b1;
    step();
    expect_val(S_REGOUT, 2'b01, "regin_1");
    expect_val(S_OUT,    2'b00, "regin_out");
    fle_regin = 1'b0;
    step();
    expect_val(S_REGOUT, 2'b00, "regin_0");

    // Reset mid-load discards the partial configuration
    config_en = 1'b1;
    ccff_head = 1'b1;
    for (int i = 0; i < 7; i++) step();
    config_en = 1'b0;
    ccff_head = 1'b0;
    reset = 1'b1;
    step();
    expect_val(S_TAIL,    2'b00, "midrst_tail");
    expect_val(S_OUT,     2'b00, "midrst_out");
    expect_val(S_CFG_ANY, 2'b00, "midrst_cfg");
    expect_val(S_REGOUT,  2'b00, "midrst_regout");
    step();
    reset = 1'b0;
    load_cfg(20'h0_8000);
    and4_checks("reload");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fle_frac_param.md
Name: fle_frac_param

Overview:
- Parametrised next-generation fracturable logic element for the CLB.
- Contains:
  - a K-input LUT that fractures into two (K-1)-LUTs;
  - two output flip-flops, each with optional bypass;
  - a register-chain input;
  - a scan chain;
  - its own configuration shift chain (ccff).
- Everything runs on one clock. The configuration chain is shifted by config_en instead of a separate programming clock.
- Instances are stitched head-to-tail by the parent CLB, both for configuration and for scan.

Parameters:
- K, 4: LUT input count; legal range 3..6.
- FRAC_EN, 1: 1 = fracture mode allowed; 0 = frac bit ignored, block always acts as a single K-LUT.
- CFG_LEN, 2**K+4: configuration chain length. Derived value; do not override.

Ports:
- clk  in  1  Fabric clock; clocks the configuration chain and the flip-flops.
- reset  in  1  Synchronous, active-high reset.
- config_en  in  1  1 = shift configuration chain one bit per cycle.
- ccff_head  in  1  Configuration serial input.
- ccff_tail  out  1  Configuration serial output; equals cfg[CFG_LEN-1].
- Test_en  in  1  1 = flip-flops form the scan chain.
- fle_in  in  K  LUT inputs.
- fle_regin  in  1  Register-chain input from the previous fle.
- fle_scin  in  1  Scan input.
- fle_out  out  2  Logic outputs.
- fle_regout  out  1  Register-chain output; Q of ff0.
- fle_scout  out  1  Scan output; Q of ff1.

Behaviour:
- Configuration map, cfg[CFG_LEN-1:0]:
  - cfg[2**K-1:0]: LUT truth table.
  - cfg[2**K]: frac.
  - cfg[2**K+1]: ff_en0.
  - cfg[2**K+2]: ff_en1.
  - cfg[2**K+3]: regin_sel.
- Configuration shift:
  - When config_en=1: cfg <= {cfg[CFG_LEN-2:0], ccff_head}.
  - The first bit shifted in lands in cfg[CFG_LEN-1] after CFG_LEN shifts.
  - ccff_tail is registered, so a bit entering at head appears at tail CFG_LEN cycles later.
  - When config_en=0, cfg holds.
- Reset:
  - cfg, ff0 and ff1 are all cleared to 0.
  - All outputs therefore read 0: fle_out=0, fle_regout=0, fle_scout=0, ccff_tail=0.
  - Reset asserted mid-configuration discards the partial load; there is no recovery state.
- Sequential-update priority: reset > config_en > Test_en > functional.
- LUT evaluation, combinational:
  - Non-fractured (frac=0 or FRAC_EN=0): lut0 = lut1 = cfg[fle_in].
  - Fractured (frac=1 and FRAC_EN=1): lo = fle_in[K-2:0]; lut0 = cfg[lo]; lut1 = cfg[2**(K-1)+lo]; fle_in[K-1] is ignored.
- Flip-flops, one cycle latency:
  - Functional update: ff0 <= regin_sel ? fle_regin : lut0; ff1 <= lut1.
  - Scan (Test_en=1, config_en=0): ff0 <= fle_scin; ff1 <= ff0.
  - While config_en=1: ff0 and ff1 hold.
- Outputs:
  - fle_out[i] = ff_en_i ? ff_i : lut_i. The bypass path is combinational, zero latency.
  - While config_en=1, fle_out is forced to 2'b00 (isolation during programming). fle_regout and fle_scout are not forced.
- Simultaneous config_en and Test_en: configuration wins; flip-flops hold.

Decomposition:
- Package fle_pkg:
  - Field-offset constants as functions of K: LUT_LSB, FRAC_BIT, FFEN0_BIT, FFEN1_BIT, REGIN_BIT.
  - cfg_len(K) function.
- Sub-module fle_ccff_chain, parametrised on CFG_LEN:
  - Contains the shift register, the reset clear and the tail tap.
- LUT mux and flip-flops stay in the top module.

Test Plan (K=4, CFG_LEN=20):
- AND4, unregistered:
  - Stimulus: reset; shift 20 bits so that cfg = {regin_sel=0, ff_en1=0, ff_en0=0, frac=0, LUT=16'h8000}.
  - Response: fle_in=4'hF -> fle_out=2'b11 in the same cycle; fle_in=4'hE -> 2'b00.
- Registered path:
  - Stimulus: same LUT with ff_en0=ff_en1=1; fle_in goes 4'hE to 4'hF at edge n.
  - Response: fle_out=2'b11 first visible after edge n+1.
- Fracture:
  - Stimulus: LUT=16'hCCAA, frac=1, no ff.
  - Response: fle_in=4'b0001 -> fle_out[0]=1, fle_out[1]=0; fle_in=4'b1010 -> fle_out[0]=0, fle_out[1]=1.
  - Repeat with FRAC_EN=0 and fle_in=4'b1010 -> both outputs equal cfg[10]=1.
- Chain pass-through:
  - Stimulus: shift a 40-bit pattern 0xA5A5_3C3C_F0.
  - Response: ccff_tail reproduces the first 20 bits, each delayed exactly 20 cycles; fle_out=0 throughout.
- Scan and regin:
  - Stimulus 1: Test_en=1, fle_scin sequence 1,0,1.
  - Response 1: fle_regout = 1,0,1 delayed 1 cycle; fle_scout = the same delayed 2 cycles.
  - Stimulus 2: Test_en=0, regin_sel=1, fle_regin=1.
  - Response 2: fle_regout=1 after one edge.
- Reset mid-load:
  - Stimulus: assert reset after 7 of 20 shifts, then deassert.
  - Response: ccff_tail=0, fle_out=0, all cfg bits read 0; a fresh 20-bit load then behaves as in the AND4 scenario.
